// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key-schedule sequencer: drives aes_key_gen, routes its S-box traffic, buffers round keys 0..NR.
// Optional macro AES_KEY_SCHED_REUSE_EN: a repeated start with the already-expanded key skips expansion.
module aes_key_sched_ctrl #(
    parameter int NR     = 10,
    parameter int KG_LAT = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_i,
    output logic         busy,
    output logic         done,
    output logic         kg_en,
    output logic         kg_gen_key,
    output logic         kg_next_rnd,
    output logic [7:0]   kg_r_con,
    output logic [127:0] kg_key,
    input  logic [31:0]  kg_sub_o,
    output logic [31:0]  kg_sub_i,
    input  logic [127:0] kg_key_o,
    output logic         sbox_req,
    output logic [31:0]  sbox_in,
    input  logic         sbox_ack,
    input  logic [31:0]  sbox_out,
    input  logic [3:0]   rk_addr,
    output logic [127:0] rk_data
);
    localparam int RW = $clog2(NR + 1);
    localparam logic [RW-1:0] LAST_ROUND = RW'(NR);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SUB, S_STEP, S_WAIT, S_STORE, S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   round_q;
    logic [2:0]      wait_q;
    logic [7:0]      rcon_q;
    logic [127:0]    key_q;
    logic [31:0]     sub_q;
    logic [127:0]    rk_mem [0:NR];
    logic            start_ok;
    logic            reuse_hit;

    function automatic logic [7:0] xtime(input logic [7:0] r);
        return r[7] ? ({r[6:0], 1'b0} ^ 8'h1b) : {r[6:0], 1'b0};
    endfunction

    assign start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));

`ifdef AES_KEY_SCHED_REUSE_EN
    logic valid_q;
    assign reuse_hit = valid_q && (key_i == rk_mem[0]);

    // Valid only while the buffer holds a complete expansion of rk_mem[0].
    always_ff @(posedge clk) begin
        if (rst)
            valid_q <= 1'b0;
        else if (start_ok && !reuse_hit)
            valid_q <= 1'b0;
        else if (state_q == S_STORE && round_q == LAST_ROUND)
            valid_q <= 1'b1;
    end
`else
    assign reuse_hit = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        busy        = 1'b0;
        done        = 1'b0;
        kg_gen_key  = 1'b0;
        kg_next_rnd = 1'b0;
        sbox_req    = 1'b0;
        sbox_in     = '0;
        case (state_q)
            S_IDLE: if (start_ok) state_d = reuse_hit ? S_DONE : S_LOAD;
            S_LOAD: begin
                busy       = 1'b1;
                kg_gen_key = 1'b1;
                state_d    = S_SUB;
            end
            S_SUB: begin
                busy     = 1'b1;
                sbox_req = 1'b1;
                sbox_in  = kg_sub_o;
                if (sbox_ack) state_d = S_STEP;
            end
            S_STEP: begin
                busy        = 1'b1;
                kg_next_rnd = 1'b1;
                state_d     = S_WAIT;
            end
            // WAIT spans KG_LAT cycles so kg_key_o has settled before STORE samples it.
            S_WAIT: begin
                busy = 1'b1;
                if (wait_q == 3'd0) state_d = S_STORE;
            end
            S_STORE: begin
                busy    = 1'b1;
                state_d = (round_q == LAST_ROUND) ? S_DONE : S_SUB;
            end
            S_DONE: begin
                done = 1'b1;
                if (start_ok) state_d = reuse_hit ? S_DONE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
        kg_en = busy;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            round_q <= '0;
            wait_q  <= '0;
            rcon_q  <= 8'h01;
            key_q   <= '0;
            sub_q   <= '0;
            for (int i = 0; i <= NR; i++) rk_mem[i] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_ok && !reuse_hit) begin
                        key_q     <= key_i;
                        rk_mem[0] <= key_i;
                    end
                end
                S_LOAD: begin
                    round_q <= RW'(1);
                    rcon_q  <= 8'h01;
                end
                S_SUB:  if (sbox_ack) sub_q <= sbox_out;
                S_STEP: wait_q <= 3'(KG_LAT - 1);
                S_WAIT: if (wait_q != 3'd0) wait_q <= wait_q - 3'd1;
                S_STORE: begin
                    rk_mem[round_q] <= kg_key_o;
                    if (round_q != LAST_ROUND) begin
                        round_q <= round_q + 1'b1;
                        rcon_q  <= xtime(rcon_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign kg_r_con = rcon_q;
    assign kg_key   = key_q;
    assign kg_sub_i = sub_q;
    assign rk_data  = (rk_addr <= 4'(NR)) ? rk_mem[rk_addr] : '0;

endmodule
